// File: rtl/sdram_rd_prefetch.sv
// rtl/sdram_rd_prefetch.sv - windowed SDRAM burst-read prefetcher feeding a pop FIFO
// Define SDRAM_RD_PREFETCH_WRAP_EN to loop over the window continuously instead of stopping.
module sdram_rd_prefetch #(
  parameter int         FIFO_DEPTH = 512,
  parameter logic [7:0] BURST_MAX  = 8'd64,
  parameter logic       AP_BIT     = 1'b1
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          init_end,
  input  logic                          cfg_start,
  input  logic [21:0]                   cfg_base,
  input  logic [21:0]                   cfg_end,
  output logic                          rd_en,
  output logic [24:0]                   rd_addri,
  output logic [7:0]                    rd_blength,
  input  logic                          rd_valid,
  input  logic [15:0]                   rd_datao,
  input  logic                          rd_end,
  input  logic                          pop,
  output logic [15:0]                   pop_data,
  output logic                          pop_valid,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_WAIT, S_ADV} state_t;

  state_t        state_q, state_d;
  logic [21:0]   cur_q, cur_d;
  logic [21:0]   end_q, end_d;
`ifdef SDRAM_RD_PREFETCH_WRAP_EN
  logic [21:0]   base_q, base_d;
`endif
  logic [24:0]   addr_q, addr_d;
  logic [7:0]    blen_q, blen_d;
  logic [7:0]    beat_q, beat_d;
  logic          done_q, done_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   pop_data_q, pop_data_d;
  logic          pop_valid_q, pop_valid_d;
  logic [15:0]   mem_q [FIFO_DEPTH];

  logic [8:0]    row_room;
  logic [21:0]   win_room;
  logic [21:0]   next_addr;
  logic [7:0]    blen_calc;
  logic [LW-1:0] free_words;
  logic          space_ok;
  logic [7:0]    eff_cnt;
  logic          push;
  logic          pop_ok;

  // Burst length limited by BURST_MAX, the end of the current row and the end of the window.
  always_comb begin
    row_room  = 9'd256 - {1'b0, cur_q[7:0]};
    win_room  = end_q - cur_q;
    blen_calc = BURST_MAX;
    if (row_room < {1'b0, blen_calc}) blen_calc = row_room[7:0];
    if (win_room < {14'd0, blen_calc}) blen_calc = win_room[7:0];
    free_words = DEPTH_L - level_q;
    space_ok   = ({24'd0, blen_calc} <= 32'(free_words));
    next_addr  = cur_q + {14'd0, blen_q};
  end

  // Beat counter restarts in REQ; surplus beats past blen are dropped.
  always_comb begin
    eff_cnt = (state_q == S_REQ) ? 8'd0 : beat_q;
    push    = ((state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_ADV))
              && rd_valid && (eff_cnt < blen_q);
    pop_ok  = pop && (level_q != '0);
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
`ifdef SDRAM_RD_PREFETCH_WRAP_EN
    base_d  = base_q;
`endif
    addr_d  = addr_q;
    blen_d  = blen_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          cur_d   = cfg_base;
          end_d   = cfg_end;
`ifdef SDRAM_RD_PREFETCH_WRAP_EN
          base_d  = cfg_base;
`endif
          done_d  = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (space_ok && init_end) begin
          addr_d  = {cur_q[21:20], cur_q[19:8], AP_BIT, 2'b00, cur_q[7:0]};
          blen_d  = blen_calc;
          state_d = S_REQ;
        end
      end
      S_REQ:  state_d = S_WAIT;
      S_WAIT: if (rd_end) state_d = S_ADV;
      S_ADV: begin
        if (next_addr == end_q) begin
`ifdef SDRAM_RD_PREFETCH_WRAP_EN
          cur_d   = base_q;
          state_d = S_CHECK;
`else
          cur_d   = next_addr;
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          cur_d   = next_addr;
          state_d = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    beat_d      = push ? eff_cnt + 8'd1 : eff_cnt;
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    pop_data_d  = pop_ok ? mem_q[rd_ptr_q] : pop_data_q;
    pop_valid_d = pop_ok;
    level_d     = level_q;
    if (push && !pop_ok) level_d = level_q + LW'(1);
    if (!push && pop_ok) level_d = level_q - LW'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= rd_datao;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      end_q       <= '0;
`ifdef SDRAM_RD_PREFETCH_WRAP_EN
      base_q      <= '0;
`endif
      addr_q      <= '0;
      blen_q      <= '0;
      beat_q      <= '0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
`ifdef SDRAM_RD_PREFETCH_WRAP_EN
      base_q      <= base_d;
`endif
      addr_q      <= addr_d;
      blen_q      <= blen_d;
      beat_q      <= beat_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  assign rd_en      = (state_q == S_REQ);
  assign rd_addri   = addr_q;
  assign rd_blength = blen_q;
  assign pop_data   = pop_data_q;
  assign pop_valid  = pop_valid_q;
  assign fifo_empty = (level_q == '0);
  assign fifo_level = level_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_sdram_rd_prefetch.sv
// tb/tb_sdram_rd_prefetch.sv - directed self-checking bench for sdram_rd_prefetch (128-word FIFO)
module tb_sdram_rd_prefetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst, init_end, cfg_start;
  logic [21:0] cfg_base, cfg_end;
  logic        rd_en;
  logic [24:0] rd_addri;
  logic [7:0]  rd_blength;
  logic        rd_valid, rd_end, pop;
  logic [15:0] rd_datao, pop_data;
  logic        pop_valid, fifo_empty, busy, done;
  logic [7:0]  fifo_level;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] dval;
  logic        seen;

  sdram_rd_prefetch #(.FIFO_DEPTH(128), .BURST_MAX(8'd64), .AP_BIT(1'b1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .cfg_start(cfg_start),
    .cfg_base(cfg_base), .cfg_end(cfg_end), .rd_en(rd_en), .rd_addri(rd_addri),
    .rd_blength(rd_blength), .rd_valid(rd_valid), .rd_datao(rd_datao), .rd_end(rd_end),
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level), .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1; cfg_start = 1'b0; rd_valid = 1'b0; rd_end = 1'b0; pop = 1'b0;
    rd_datao = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic start(input logic [21:0] b, input logic [21:0] e);
    cfg_base = b; cfg_end = e; cfg_start = 1'b1;
    @(negedge sys_clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [24:0] addr, input logic [7:0] blen);
    for (int i = 0; i < 50; i++) begin
      if (rd_en) break;
      @(negedge sys_clk);
    end
    chk({tag, "_rd_en"}, rd_en, 1);
    chk({tag, "_addr"}, rd_addri, addr);
    chk({tag, "_blen"}, rd_blength, blen);
  endtask

  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      rd_valid = 1'b1; rd_datao = dval; dval = dval + 16'd1;
      @(negedge sys_clk);
    end
    rd_valid = 1'b0; rd_end = 1'b1;
    @(negedge sys_clk);
    rd_end = 1'b0;
  endtask

  initial begin
    init_end = 1'b1; cfg_base = '0; cfg_end = '0;
    apply_reset();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_addr", rd_addri, 0);
    chk("rst_blen", rd_blength, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pop_valid", pop_valid, 0);

    // Basic two-burst window
    dval = 16'h0000;
    start(22'h000000, 22'h000080);
    chk("basic_busy", busy, 1);
    wait_req("basic_r1", 25'h0000400, 8'd64);
    serve(64);
    wait_req("basic_r2", 25'h0000440, 8'd64);
    serve(64);
    repeat (3) @(negedge sys_clk);
    chk("basic_level", fifo_level, 128);
    chk("basic_done", done, 1);
    chk("basic_busy_end", busy, 0);
    pop = 1'b1; @(negedge sys_clk); pop = 1'b0;
    chk("basic_pop_valid", pop_valid, 1);
    chk("basic_pop_data", pop_data, 16'h0000);
    chk("basic_level_pop", fifo_level, 127);

    // Row boundary, surplus beats, back-pressure, push+pop
    apply_reset();
    dval = 16'h1000;
    start(22'h0000F0, 22'h000200);
    wait_req("row_r1", 25'h00004F0, 8'd16);
    serve(18);
    chk("extra_level", fifo_level, 16);
    wait_req("row_r2", 25'h0000C00, 8'd64);
    serve(64);
    chk("row_level", fifo_level, 80);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) cfg_start = 1'b1;
      if (i == 4) cfg_start = 1'b0;
      @(negedge sys_clk);
      if (rd_en) seen = 1'b1;
    end
    chk("bp_stall", seen, 0);
    pop = 1'b1;
    repeat (15) @(negedge sys_clk);
    pop = 1'b0;
    repeat (5) begin
      @(negedge sys_clk);
      if (rd_en) seen = 1'b1;
    end
    chk("bp_stall_65", seen, 0);
    chk("bp_level_65", fifo_level, 65);
    pop = 1'b1; @(negedge sys_clk); pop = 1'b0;
    chk("bp_pop16_data", pop_data, 16'h100F);
    chk("bp_level_64", fifo_level, 64);
    for (int i = 0; i < 2; i++) begin
      if (!rd_en) @(negedge sys_clk);
    end
    wait_req("bp_r3", 25'h0000C40, 8'd64);
    for (int i = 0; i < 64; i++) begin
      rd_valid = 1'b1; rd_datao = dval; dval = dval + 16'd1; pop = 1'b1;
      @(negedge sys_clk);
      if (i == 0) chk("pp_first_data", pop_data, 16'h1012);
      if (i == 30) chk("pp_level_mid", fifo_level, 64);
    end
    rd_valid = 1'b0; pop = 1'b0; rd_end = 1'b1;
    @(negedge sys_clk);
    rd_end = 1'b0;
    chk("pp_level_end", fifo_level, 64);

    // Pop on empty
    apply_reset();
    pop = 1'b1; @(negedge sys_clk); pop = 1'b0;
    chk("empty_pop_valid", pop_valid, 0);
    chk("empty_level", fifo_level, 0);
    chk("empty_flag", fifo_empty, 1);

    // Reset mid-burst
    dval = 16'h2000;
    start(22'h000000, 22'h000080);
    wait_req("mr_r1", 25'h0000400, 8'd64);
    for (int i = 0; i < 10; i++) begin
      rd_valid = 1'b1; rd_datao = dval; dval = dval + 16'd1;
      @(negedge sys_clk);
    end
    rd_valid = 1'b0;
    chk("mr_level_pre", fifo_level, 10);
    sys_rst = 1'b1; @(negedge sys_clk); sys_rst = 1'b0;
    chk("mr_rd_en", rd_en, 0);
    chk("mr_level", fifo_level, 0);
    chk("mr_busy", busy, 0);
    rd_valid = 1'b1; rd_end = 1'b1; @(negedge sys_clk);
    rd_valid = 1'b0; rd_end = 1'b0; @(negedge sys_clk);
    chk("mr_late_level", fifo_level, 0);
    chk("mr_late_busy", busy, 0);
    start(22'h000020, 22'h000080);
    wait_req("mr_restart", 25'h0000420, 8'd64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
